// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   arb_state_t                - arbiter FSM encoding (IDLE, XFER)
//   UART_TIMEOUT_CYCLES_DEFAULT - default stall limit for the optional timeout
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int UART_TIMEOUT_CYCLES_DEFAULT = 4096;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner selection (purely combinational).
// The search starts at index ptr and wraps modulo N. The first
// asserted request found is the winner.
// Ports:
//   req    - request vector
//   ptr    - index where the search begins
//   winner - one-hot winning request, zero when no request
//   any    - high when at least one request is asserted
module rr_select #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates whole byte messages from NUM_REQ requesters onto one UART
// transmit byte stream. A requester owns the transmitter from its grant
// until its last byte is accepted. Arbitration is round-robin and
// starts after the previous owner.
// Optional feature (macro UART_ARB_TIMEOUT_EN): abort an owner whose
// valid stays low for TIMEOUT_CYCLES consecutive cycles.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   req_valid/data/last - per-requester byte stream (byte i at [8i+7:8i])
//   req_ready           - per-requester accept (only the owner, in XFER)
//   tx_valid/data       - byte offered to the transmitter
//   tx_ready            - transmitter accepts the offered byte
//   grant               - one-hot current owner, zero when idle
//   timeout             - one-cycle pulse on the aborted owner's bit
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rr_winner;
    logic               rr_any;
    logic               stall_hit;

    // Search begins one past the previous owner so every waiting
    // requester is reached within NUM_REQ messages.
    assign rr_ptr = (last_owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_owner_q + 1'b1;

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (rr_winner),
        .any    (rr_any)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner = IDX_W'(i);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_q;

    // stall_cnt_q holds the number of earlier consecutive stalled cycles,
    // so the limit is reached during the TIMEOUT_CYCLES-th stalled cycle.
    assign stall_hit = (state_q == XFER) && !req_valid[owner] &&
                       (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q != XFER || req_valid[owner] || stall_hit) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign timeout = stall_hit ? grant_q : '0;
`else
    assign stall_hit = 1'b0;
    assign timeout   = '0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_winner;
                    state_d = XFER;
                end
            end
            XFER: begin
                tx_valid         = req_valid[owner];
                if (tx_valid) tx_data = req_data[{owner, 3'b000} +: 8];
                req_ready[owner] = tx_ready;
                if ((tx_valid && tx_ready && req_last[owner]) || stall_hit) begin
                    last_owner_d = owner;
                    grant_d      = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with NUM_REQ=3, TIMEOUT_CYCLES=16.
// Timeout behaviour is checked when UART_ARB_TIMEOUT_EN is defined;
// otherwise the bench checks that a stalled grant is held.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [2:0]  grant;
    logic [2:0]  timeout;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 3'b000;
        req_data  = 24'h0;
        req_last  = 3'b000;
        tx_ready  = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, req_ready, tx_valid, tx_data, timeout} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: grant=%b req_ready=%b tx_valid=%b tx_data=%h timeout=%b expected all 0",
                     grant, req_ready, tx_valid, tx_data, timeout);
        end
    endtask

    task automatic test_single_message();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        do_reset();
        req_valid = 3'b001;
        req_data  = {16'h0, bytes[0]};
        #1;
        checks++;
        if (grant !== 3'b000 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL msg_idle: grant=%b req_ready=%b expected 000/000", grant, req_ready);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            req_data = {16'h0, bytes[b]};
            req_last = (b == 2) ? 3'b001 : 3'b000;
            #1;
            checks++;
            if (grant !== 3'b001 || tx_valid !== 1'b1 || tx_data !== bytes[b] || req_ready !== 3'b001) begin
                errors++;
                $display("FAIL msg_byte%0d: grant=%b tx_valid=%b tx_data=%h req_ready=%b expected 001/1/%h/001",
                         b, grant, tx_valid, tx_data, req_ready, bytes[b]);
            end
        end
        tick();
        req_valid = 3'b000;
        req_last  = 3'b000;
        #1;
        checks++;
        if (grant !== 3'b000 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL msg_release: grant=%b tx_valid=%b tx_data=%h expected 000/0/00", grant, tx_valid, tx_data);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_grant [7];
        logic [7:0] exp_data  [7];
        exp_grant[0] = 3'b001; exp_data[0] = 8'hA0;
        exp_grant[1] = 3'b000; exp_data[1] = 8'h00;
        exp_grant[2] = 3'b010; exp_data[2] = 8'hA1;
        exp_grant[3] = 3'b000; exp_data[3] = 8'h00;
        exp_grant[4] = 3'b100; exp_data[4] = 8'hA2;
        exp_grant[5] = 3'b000; exp_data[5] = 8'h00;
        exp_grant[6] = 3'b001; exp_data[6] = 8'hA0;
        do_reset();
        req_valid = 3'b111;
        req_last  = 3'b111;
        req_data  = 24'hA2_A1_A0;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (grant !== exp_grant[c] || tx_data !== exp_data[c]) begin
                errors++;
                $display("FAIL rr_cycle%0d: grant=%b tx_data=%h expected %b/%h",
                         c, grant, tx_data, exp_grant[c], exp_data[c]);
            end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_hold_off();
        logic [7:0] b1 [3];
        b1[0] = 8'hB0; b1[1] = 8'hB1; b1[2] = 8'hB2;
        do_reset();
        req_valid = 3'b010;
        req_data  = {8'hC0, b1[0], 8'h00};
        tick();
        req_valid = 3'b110;
        req_last  = 3'b100;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) tick();
            req_data = {8'hC0, b1[b], 8'h00};
            req_last = (b == 2) ? 3'b110 : 3'b100;
            #1;
            checks++;
            if (grant !== 3'b010 || req_ready !== 3'b010 || tx_data !== b1[b]) begin
                errors++;
                $display("FAIL hold_byte%0d: grant=%b req_ready=%b tx_data=%h expected 010/010/%h",
                         b, grant, req_ready, tx_data, b1[b]);
            end
        end
        tick();
        req_valid = 3'b100;
        #1;
        checks++;
        if (grant !== 3'b000 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL hold_gap: grant=%b req_ready=%b expected 000/000", grant, req_ready);
        end
        tick();
        checks++;
        if (grant !== 3'b100 || tx_data !== 8'hC0 || req_ready !== 3'b100) begin
            errors++;
            $display("FAIL hold_next: grant=%b tx_data=%h req_ready=%b expected 100/c0/100", grant, tx_data, req_ready);
        end
        tick();
        req_valid = 3'b000;
        req_last  = 3'b000;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 3'b001;
        req_data  = 24'h00_00_55;
        tx_ready  = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (grant !== 3'b001 || tx_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_cycle%0d: grant=%b tx_valid=%b tx_data=%h req_ready=%b expected 001/1/55/000",
                         c, grant, tx_valid, tx_data, req_ready);
            end
            tick();
        end
        tx_ready = 1'b1;
        req_last = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL stall_resume: req_ready=%b tx_data=%h expected 001/55", req_ready, tx_data);
        end
        tick();
        req_valid = 3'b000;
        req_last  = 3'b000;
        #1;
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL stall_release: grant=%b expected 000", grant);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        req_valid = 3'b001;
        req_data  = 24'h00_00_11;
        tick();
        tick();
        // Owner 0 goes quiet after its first byte; requester 1 waits.
        req_valid = 3'b010;
        req_data  = 24'h00_22_00;
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            #1;
            checks++;
            if (timeout !== ((k == 16) ? 3'b001 : 3'b000) || grant !== 3'b001 ||
                tx_valid !== 1'b0 || tx_data !== 8'h00) begin
                errors++;
                $display("FAIL to_stall%0d: timeout=%b grant=%b tx_valid=%b tx_data=%h expected %b/001/0/00",
                         k, timeout, grant, tx_valid, tx_data, (k == 16) ? 3'b001 : 3'b000);
            end
        end
        tick();
        checks++;
        if (timeout !== 3'b000 || grant !== 3'b000) begin
            errors++;
            $display("FAIL to_release: timeout=%b grant=%b expected 000/000", timeout, grant);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL to_next: grant=%b tx_data=%h expected 010/22", grant, tx_data);
        end
        req_last = 3'b010;
        tick();
`else
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) tick();
            #1;
            checks++;
            if (timeout !== 3'b000 || grant !== 3'b001 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
                errors++;
                $display("FAIL drop_hold%0d: timeout=%b grant=%b tx_valid=%b tx_data=%h expected 000/001/0/00",
                         k, timeout, grant, tx_valid, tx_data);
            end
        end
        req_valid = 3'b011;
        req_data  = 24'h00_22_12;
        req_last  = 3'b001;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h12 || req_ready !== 3'b001) begin
            errors++;
            $display("FAIL drop_resume: tx_valid=%b tx_data=%h req_ready=%b expected 1/12/001",
                     tx_valid, tx_data, req_ready);
        end
        tick();
        req_valid = 3'b010;
        req_last  = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL drop_next: grant=%b tx_data=%h expected 010/22", grant, tx_data);
        end
`endif
        tick();
        req_valid = 3'b000;
        req_last  = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 3'b001;
        req_data  = 24'h00_00_61;
        tick();
        tick();
        req_data = 24'h00_00_62;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, req_ready, tx_valid, tx_data, timeout} !== 20'h0) begin
            errors++;
            $display("FAIL rst_async: grant=%b req_ready=%b tx_valid=%b tx_data=%h timeout=%b expected all 0",
                     grant, req_ready, tx_valid, tx_data, timeout);
        end
        tick();
        rst       = 1'b0;
        req_valid = 3'b111;
        req_last  = 3'b111;
        req_data  = 24'h83_82_81;
        tick();
        checks++;
        if (grant !== 3'b001 || tx_data !== 8'h81) begin
            errors++;
            $display("FAIL rst_first: grant=%b tx_data=%h expected 001/81", grant, tx_data);
        end
        req_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b000;
        req_data  = 24'h0;
        req_last  = 3'b000;
        tx_ready  = 1'b1;
        test_reset();
        test_single_message();
        test_round_robin();
        test_hold_off();
        test_backpressure();
        test_owner_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
